serial_adder_top: RTL and testbench

- Bit-serial unsigned adder: captures two WIDTH-bit operands on a start request and adds them LSB-first, one bit per clock, through a single full adder and a carry flip-flop.
- Presents the WIDTH+1-bit sum with a done flag.
- Used as a small self-contained arithmetic demo/accelerator block behind simple start/done control.

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_full_adder_bit.sv | 14 +
 rtl/serial_adder_top.sv | 102 ++++++++++
 tb/tb_serial_adder_top.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Holds the controller state encoding and the default operand width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_full_adder_bit.sv
// Combinational 1-bit full adder used as the single arithmetic
// element of the bit-serial adder.
module full_adder_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/serial_adder_top.sv
// Bit-serial unsigned adder: operands are captured on start and summed
// LSB-first through one full adder and a carry flop, one bit per clock.
module serial_adder_top
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic [WIDTH:0]   result,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr_reg;
   logic [WIDTH-1:0] b_sr_reg;
   logic [WIDTH-1:0] sum_reg;
   logic [WIDTH:0]   result_reg;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg;
   logic             load;
   logic             last;
   logic             bit_sum;
   logic             bit_cout;

   full_adder_bit u_fa (
      .a    (a_sr_reg[0]),
      .b    (b_sr_reg[0]),
      .cin  (carry_reg),
      .sum  (bit_sum),
      .cout (bit_cout)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // A start request is honoured only outside RUN, so an operation in flight
   // cannot be disturbed.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      last       = 1'b0;
      case (state_reg)
         IDLE, DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            if (cnt_reg == LAST_CNT) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         sum_reg    <= '0;
         result_reg <= '0;
         cnt_reg    <= '0;
         carry_reg  <= 1'b0;
      end else if (load) begin
         a_sr_reg  <= data_a;
         b_sr_reg  <= data_b;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
      end else if (state_reg == RUN) begin
         a_sr_reg  <= a_sr_reg >> 1;
         b_sr_reg  <= b_sr_reg >> 1;
         sum_reg   <= {bit_sum, sum_reg[WIDTH-1:1]};
         carry_reg <= bit_cout;
         cnt_reg   <= cnt_reg + CW'(1);
         // The final bit and its carry-out go straight into the result so it
         // is valid on the same edge that enters DONE.
         if (last) begin
            result_reg <= {bit_cout, bit_sum, sum_reg[WIDTH-1:1]};
         end
      end
   end

   assign result = result_reg;
   assign done   = (state_reg == DONE);

endmodule : serial_adder_top

// File: tb/tb_serial_adder_top.sv
// Self-checking bench for serial_adder_top: directed corner cases plus
// random operands checked against plain integer addition.
module tb_serial_adder_top;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] data_a;
   logic [WIDTH-1:0] data_b;
   logic [WIDTH:0]   result;
   logic             done;

   int total;
   int bad;
   logic [WIDTH:0] held;

   serial_adder_top #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .data_a (data_a),
      .data_b (data_b),
      .result (result),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
         $error("%s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Issue one add, scramble the operand inputs after the load edge, and
   // check the done latency and final sum against integer addition.
   task automatic run_op(input int a, input int b, input string tag);
      int exp_sum;
      exp_sum = a + b;
      @(negedge clk);
      data_a = WIDTH'(a);
      data_b = WIDTH'(b);
      start  = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_load_done"}, 32'(done), 32'd0);
      check({tag, "_load_hold"}, 32'(result), 32'(held));
      @(negedge clk);
      start  = 1'b0;
      data_a = WIDTH'($urandom);
      data_b = WIDTH'($urandom);
      for (int k = 1; k <= WIDTH; k++) begin
         @(posedge clk);
         #1;
         if (k < WIDTH) begin
            check({tag, "_busy_done"}, 32'(done), 32'd0);
         end
      end
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_result"}, 32'(result), 32'(exp_sum));
      $display("op %s: a=%0d b=%0d result=%0d done=%0d", tag, a, b, result, done);
      held = WIDTH'(0) + (WIDTH+1)'(exp_sum);
   endtask

   initial begin
      int ra;
      int rb;
      total  = 0;
      bad    = 0;
      held   = '0;
      start  = 1'b0;
      data_a = '0;
      data_b = '0;
      rst    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_result", 32'(result), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op(128, 128, "basic");
      repeat (3) @(posedge clk);
      #1;
      check("done_hold", 32'(done), 32'd1);
      check("result_hold", 32'(result), 32'd256);
      run_op(255, 255, "max");
      run_op(0, 0, "zero");
      run_op(1, 255, "carry");

      // A second start while busy must be ignored.
      @(negedge clk);
      data_a = 8'd3;
      data_b = 8'd4;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      data_a = 8'd100;
      data_b = 8'd100;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 4; k <= WIDTH; k++) begin
         @(posedge clk);
         #1;
         if (k < WIDTH) check("ignore_busy_done", 32'(done), 32'd0);
      end
      check("ignore_done", 32'(done), 32'd1);
      check("ignore_result", 32'(result), 32'd7);
      $display("op ignore: a=3 b=4 result=%0d done=%0d", result, done);
      held = 9'd7;

      // Asynchronous reset in the middle of an operation.
      @(negedge clk);
      data_a = 8'd200;
      data_b = 8'd100;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_result", 32'(result), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      $display("op abort: result=%0d done=%0d", result, done);
      repeat (WIDTH + 1) @(posedge clk);
      #1;
      check("abort_stay_done", 32'(done), 32'd0);
      @(negedge clk);
      rst  = 1'b1;
      held = '0;
      run_op(200, 100, "after_abort");

      // Start held high: one done pulse every WIDTH+1 cycles.
      @(negedge clk);
      data_a = 8'd10;
      data_b = 8'd20;
      start  = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 3 * (WIDTH + 1); k++) begin
         @(posedge clk);
         #1;
         check("b2b_done", 32'(done), (k % (WIDTH + 1) == WIDTH) ? 32'd1 : 32'd0);
         if (k % (WIDTH + 1) == WIDTH) begin
            check("b2b_result", 32'(result), 32'd30);
            $display("op b2b: cycle=%0d result=%0d done=%0d", k, result, done);
         end
      end
      @(negedge clk);
      start = 1'b0;
      repeat (WIDTH + 2) @(posedge clk);
      held = 9'd30;

      for (int n = 0; n < 16; n++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         run_op(ra, rb, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_adder_top
